// File: rtl/prog_freq_div.sv
// Programmable frequency divider: tick pulse and 50% square output.
// The divisor can be reloaded at run time and takes effect only on a period boundary.
module prog_freq_div #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iSync,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iDiv,
  input  logic             iMode,
  output logic             oTick,
  output logic             oSquare,
  output logic             oDiv,
  output logic             oLoadAck,
  output logic             oLoadErr,
  output logic [WIDTH-1:0] oCount
);

  localparam logic [WIDTH-1:0] DEF_DIV_C = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] c_q,  c_d;
  logic [WIDTH-1:0] da_q, da_d;
  logic [WIDTH-1:0] dp_q, dp_d;
  logic             p_q,  p_d;
  logic             tick_q, tick_d;
  logic             sq_q,   sq_d;
  logic             ack_q,  ack_d;
  logic             err_q,  err_d;

  logic             tc_s;
  logic             div_nz_s;

  // Terminal count and divisor validity decode.
  always_comb begin
    tc_s     = (c_q == (da_q - ONE_C));
    div_nz_s = (iDiv != ZERO_C);
  end

  // Next-state logic; an older pending divisor is applied before a same-cycle load is captured.
  always_comb begin
    c_d    = c_q;
    da_d   = da_q;
    dp_d   = dp_q;
    p_d    = p_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    ack_d  = 1'b0;
    err_d  = 1'b0;

    if (iSync) begin
      c_d  = ZERO_C;
      sq_d = 1'b0;
      if (p_q) begin
        da_d  = dp_q;
        p_d   = 1'b0;
        ack_d = 1'b1;
      end else begin
        da_d  = da_q;
      end
    end else if (iEn) begin
      if (tc_s) begin
        c_d    = ZERO_C;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
        if (p_q) begin
          da_d  = dp_q;
          p_d   = 1'b0;
          ack_d = 1'b1;
        end else begin
          da_d  = da_q;
        end
      end else begin
        c_d = c_q + ONE_C;
      end
    end else begin
      c_d = c_q;
    end

    if (iLoad && div_nz_s) begin
      dp_d = iDiv;
      p_d  = 1'b1;
    end else begin
      err_d = iLoad;
    end
  end

  // State registers with synchronous reset; reset drops any pending load silently.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      c_q    <= ZERO_C;
      da_q   <= DEF_DIV_C;
      dp_q   <= DEF_DIV_C;
      p_q    <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      da_q   <= da_d;
      dp_q   <= dp_d;
      p_q    <= p_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  // Output mapping; oDiv follows iMode without a register stage.
  always_comb begin
    oTick    = tick_q;
    oSquare  = sq_q;
    oLoadAck = ack_q;
    oLoadErr = err_q;
    oCount   = c_q;
    if (iMode) begin
      oDiv = sq_q;
    end else begin
      oDiv = tick_q;
    end
  end

endmodule

// File: tb/tb_prog_freq_div.sv
// Bench for prog_freq_div: vector table, directed corner sequences and
// randomized traffic against a period/queue based reference model.
module tb_prog_freq_div;

  localparam int W = 8;

  logic         iClk, iRst, iEn, iSync, iLoad, iMode;
  logic [W-1:0] iDiv;
  logic         oTick, oSquare, oDiv, oLoadAck, oLoadErr;
  logic [W-1:0] oCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the current period, ticks since restart.
  int m_da;
  int m_pend[$];
  int m_pos;
  int m_ticks;
  bit m_tick, m_ack, m_err;

  typedef struct {
    logic         en, sync, load;
    logic [W-1:0] div;
    logic         mode;
    logic         tick, sq;
    logic [W-1:0] cnt;
    logic         ack, err, odiv;
  } vec_t;
  vec_t vecs[12];

  prog_freq_div #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iSync(iSync), .iLoad(iLoad),
    .iDiv(iDiv), .iMode(iMode), .oTick(oTick), .oSquare(oSquare),
    .oDiv(oDiv), .oLoadAck(oLoadAck), .oLoadErr(oLoadErr), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, en, sync, load, input int div);
    if (rst) begin
      m_da = 4; m_pend.delete(); m_pos = 0; m_ticks = 0;
      m_tick = 0; m_ack = 0; m_err = 0;
    end else begin
      m_tick = 0; m_ack = 0;
      m_err = load && (div == 0);
      if (sync) begin
        m_pos = 0; m_ticks = 0;
        if (m_pend.size() > 0) begin m_da = m_pend.pop_front(); m_ack = 1; end
      end else if (en) begin
        if (m_pos + 1 == m_da) begin
          m_pos = 0; m_ticks++; m_tick = 1;
          if (m_pend.size() > 0) begin m_da = m_pend.pop_front(); m_ack = 1; end
        end else begin
          m_pos++;
        end
      end
      if (load && div != 0) begin m_pend.delete(); m_pend.push_back(div); end
    end
  endtask

  // One clock: drive, step model, clock, compare every output to the model.
  task automatic cycle(input logic rst, en, sync, load, input logic [W-1:0] div, input logic mode);
    bit m_sq;
    iRst = rst; iEn = en; iSync = sync; iLoad = load; iDiv = div; iMode = mode;
    model_step(rst, en, sync, load, int'(div));
    @(posedge iClk);
    #1;
    m_sq = (m_ticks % 2) == 1;
    check("model_tick",  oTick,    m_tick);
    check("model_sq",    oSquare,  m_sq);
    check("model_cnt",   oCount,   m_pos);
    check("model_ack",   oLoadAck, m_ack);
    check("model_err",   oLoadErr, m_err);
    check("model_odiv",  oDiv,     mode ? m_sq : m_tick);
  endtask

  task automatic run_to_tick(input int limit, output int n, output int acks);
    n = -1; acks = 0;
    for (int i = 1; i <= limit; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      if (oLoadAck) acks++;
      if (oTick) begin n = i; break; end
    end
  endtask

  initial begin
    int n, acks;

    vecs[0]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b0,1'b0,8'd1,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,8'd0,1'b1, 1'b0,1'b0,8'd2,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b0,1'b0,8'd3,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b1,1'b1,8'd0,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,8'd0,1'b1, 1'b0,1'b1,8'd1,1'b0,1'b1,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b0,1'b1,8'd2,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,8'd0,1'b1, 1'b0,1'b1,8'd3,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b1,1'b0,1'b0,8'd0,1'b1, 1'b0,1'b0,8'd1,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b0,1'b0,8'd2,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b0,8'd0,1'b0, 1'b0,1'b0,8'd3,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,8'd0,1'b1, 1'b1,1'b1,8'd0,1'b0,1'b0,1'b1};

    // Reset with every other input active.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'd9, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    check("rst_cnt", oCount, 0);
    check("rst_tick", oTick, 0);
    check("rst_sq", oSquare, 0);
    check("rst_ack", oLoadAck, 0);
    check("rst_err", oLoadErr, 0);

    // Free-running period 4 with a rejected zero load in row 5.
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, vecs[i].en, vecs[i].sync, vecs[i].load, vecs[i].div, vecs[i].mode);
      check($sformatf("vec%0d_tick", i), oTick, vecs[i].tick);
      check($sformatf("vec%0d_sq", i), oSquare, vecs[i].sq);
      check($sformatf("vec%0d_cnt", i), oCount, vecs[i].cnt);
      check($sformatf("vec%0d_ack", i), oLoadAck, vecs[i].ack);
      check($sformatf("vec%0d_err", i), oLoadErr, vecs[i].err);
      check($sformatf("vec%0d_odiv", i), oDiv, vecs[i].odiv);
    end

    // Enable low for 10 cycles at count 2.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      check("hold_cnt", oCount, 2);
      check("hold_tick", oTick, 0);
    end
    run_to_tick(20, n, acks);
    check("resume_edges", n, 2);

    // Load 6 at count 1: applies only at the terminal count.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd6, 1'b0);
    run_to_tick(20, n, acks);
    check("load6_first_tick", n, 2);
    check("load6_ack_at_tc", oLoadAck, 1);
    run_to_tick(20, n, acks);
    check("load6_period_a", n, 6);
    check("load6_no_reack", acks, 0);
    run_to_tick(20, n, acks);
    check("load6_period_b", n, 6);

    // Two loads before the terminal count: last one wins, single ack.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
    run_to_tick(20, n, acks);
    check("lastwin_first_tick", n, 4);
    check("lastwin_acks", acks, 1);
    run_to_tick(20, n, acks);
    check("lastwin_period_a", n, 3);
    check("lastwin_acks_after", acks, 0);
    run_to_tick(20, n, acks);
    check("lastwin_period_b", n, 3);

    // Sync at count 2 with 7 pending.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    check("presync_cnt", oCount, 2);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    check("sync_cnt", oCount, 0);
    check("sync_sq", oSquare, 0);
    check("sync_tick", oTick, 0);
    check("sync_ack", oLoadAck, 1);
    run_to_tick(20, n, acks);
    check("sync7_period", n, 7);
    check("sync7_sq", oSquare, 1);

    // Divisor 1 via load then sync: tick constantly high.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("div1_ack", oLoadAck, 1);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
      check("div1_tick", oTick, 1);
      check("div1_sq", oSquare, (i % 2) == 1);
    end

    // Reset discards a pending load without acknowledge.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    run_to_tick(20, n, acks);
    check("rst_pend_period", n, 4);
    check("rst_pend_acks", acks, 0);
    run_to_tick(20, n, acks);
    check("rst_pend_period_b", n, 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199) == 0),
            ($urandom_range(9) < 8),
            ($urandom_range(39) == 0),
            ($urandom_range(19) == 0),
            8'($urandom_range(9)),
            1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
